// File: rtl/sqd_pkg.sv
// Shared types and helpers for the serial mod-3 residue path (feeder and tracker).
package sqd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int SWF_DEF_WIDTH = 8;

  localparam logic [1:0] R0 = 2'b00;
  localparam logic [1:0] R1 = 2'b01;
  localparam logic [1:0] R2 = 2'b10;

  // Even-index bits weigh 1 (4^k mod 3), odd-index bits weigh 2 (2*4^k mod 3).
  function automatic logic [1:0] mod3_of(input logic [31:0] word);
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (word[i]) s += (i % 2 == 0) ? 1 : 2;
    end
    return 2'(s % 3);
  endfunction

endpackage

// File: rtl/mod3_reduce.sv
// Combinational WIDTH-bit word to mod-3 residue reducer.
module mod3_reduce
  import sqd_pkg::*;
#(
  parameter int WIDTH = SWF_DEF_WIDTH
) (
  input  logic [WIDTH-1:0] word,
  output logic [1:0]       rem
);

  assign rem = mod3_of(32'(word));

endmodule

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial word feeder with one-entry holding register and word framing.
// Define SWF_EXP_REM_EN to add the exp_rem/exp_rem_valid expected-residue outputs.
module serial_word_feeder
  import sqd_pkg::*;
#(
  parameter int WIDTH = SWF_DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
`ifdef SWF_EXP_REM_EN
  ,
  output logic [1:0]       exp_rem,
  output logic             exp_rem_valid
`endif
);

  state_t             state, state_d;
  logic [WIDTH-1:0]   shreg, shreg_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [WIDTH-1:0]   pend_data;
  logic               pend_full, pend_full_d;
  logic               cnt_is_last, load_fire, accept;

  assign cnt_is_last = (cnt == CNT_W'(WIDTH - 1));
  assign load_fire   = pend_full && ((state == IDLE) || (state == SHIFT && cnt_is_last));
  assign in_ready    = !reset && (!pend_full || load_fire);
  assign accept      = in_valid && in_ready;

  assign ser_valid = (state == SHIFT);
  assign ser_bit   = ser_valid && shreg[WIDTH-1];
  assign ser_first = ser_valid && (cnt == '0);
  assign ser_last  = ser_valid && cnt_is_last;
  assign busy      = ser_valid || pend_full;

  always_comb begin
    state_d     = state;
    shreg_d     = shreg;
    cnt_d       = cnt;
    pend_full_d = pend_full;
    if (accept)         pend_full_d = 1'b1;
    else if (load_fire) pend_full_d = 1'b0;
    case (state)
      IDLE: begin
        if (load_fire) begin
          state_d = SHIFT;
          shreg_d = pend_data;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cnt_is_last) begin
          cnt_d = '0;
          // Reload on the last bit keeps the next word's MSB directly after this LSB.
          if (load_fire) shreg_d = pend_data;
          else begin
            state_d = IDLE;
            shreg_d = shreg << 1;
          end
        end else begin
          shreg_d = shreg << 1;
          cnt_d   = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      pend_full <= 1'b0;
      pend_data <= '0;
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      cnt       <= cnt_d;
      pend_full <= pend_full_d;
      if (accept) pend_data <= in_data;
    end
  end

`ifdef SWF_EXP_REM_EN
  logic [1:0] pend_rem;

  mod3_reduce #(.WIDTH(WIDTH)) u_mod3_reduce (
    .word (pend_data),
    .rem  (pend_rem)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)          exp_rem <= R0;
    else if (load_fire) exp_rem <= pend_rem;
  end

  assign exp_rem_valid = ser_last;
`endif

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed self-checking bench for serial_word_feeder (WIDTH=8).
module tb_serial_word_feeder;
  import sqd_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready, ser_bit, ser_valid, ser_first, ser_last, busy;
`ifdef SWF_EXP_REM_EN
  logic [1:0] exp_rem;
  logic       exp_rem_valid;
`endif

  serial_word_feeder #(.WIDTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid),
    .ser_first (ser_first),
    .ser_last  (ser_last),
    .busy      (busy)
`ifdef SWF_EXP_REM_EN
    ,
    .exp_rem       (exp_rem),
    .exp_rem_valid (exp_rem_valid)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic       b;
    logic       f;
    logic       l;
    int         cyc;
    logic [1:0] rem;
  } smp_t;

  smp_t q[$];
  int   cyc = 0;

  // Serial-line monitor: logs every valid bit, requires ser_bit=0 while idle.
  always @(negedge clock) begin
    smp_t s;
    cyc++;
    if (!reset) begin
      if (ser_valid) begin
        s.b = ser_bit; s.f = ser_first; s.l = ser_last; s.cyc = cyc; s.rem = 2'b00;
`ifdef SWF_EXP_REM_EN
        s.rem = exp_rem;
        check("exp_rem_valid", 32'(exp_rem_valid), 32'(ser_last));
`endif
        q.push_back(s);
      end else begin
        check("idle_bit", 32'(ser_bit), 32'd0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] w);
    bit done;
    done     = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      done = in_ready;
      @(posedge clock);
      #1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  // Checks one 8-bit word in the log; residue model is the downstream tracker
  // (r = 2r + b mod 3, restarted on ser_first).
  task automatic check_word(input int base, input logic [7:0] w, input logic [1:0] rem,
                            input string tag);
    logic [1:0] r;
    r = 2'd0;
    if (q.size() < base + 8) begin
      check({tag, "_len"}, 32'(q.size()), 32'(base + 8));
      return;
    end
    for (int i = 0; i < 8; i++) begin
      check({tag, "_bit"}, 32'(q[base+i].b), 32'(w[7-i]));
      check({tag, "_first"}, 32'(q[base+i].f), 32'(i == 0));
      check({tag, "_last"}, 32'(q[base+i].l), 32'(i == 7));
      check({tag, "_contig"}, 32'(q[base+i].cyc), 32'(q[base].cyc + i));
      if (q[base+i].f) r = 2'd0;
      r = 2'((2 * int'(r) + int'(q[base+i].b)) % 3);
    end
    check({tag, "_track"}, 32'(r), 32'(rem));
`ifdef SWF_EXP_REM_EN
    check({tag, "_exprem"}, 32'(q[base+7].rem), 32'(rem));
`endif
  endtask

  initial begin
    // Reset
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_outs", {27'd0, ser_bit, ser_valid, ser_first, ser_last, busy}, 32'd0);
    #28 reset = 1'b0;
    step(1);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_outs", {27'd0, ser_bit, ser_valid, ser_first, ser_last, busy}, 32'd0);

    // Single word A5
    q.delete();
    send(8'hA5);
    in_valid = 1'b0;
    check("a5_lat_valid", 32'(ser_valid), 32'd0);
    check("a5_lat_busy", 32'(busy), 32'd1);
    step(1);
    check("a5_msb", {29'd0, ser_valid, ser_first, ser_bit}, 32'h7);
    step(10);
    check("a5_count", 32'(q.size()), 32'd8);
    check_word(0, 8'hA5, 2'd0, "a5");
    check("a5_idle", {30'd0, ser_valid, busy}, 32'd0);

    // Back-to-back 07, 80, FF
    q.delete();
    send(8'h07);
    send(8'h80);
    check("b2b_ready_drop", 32'(in_ready), 32'd0);
    send(8'hFF);
    in_valid = 1'b0;
    step(30);
    check("b2b_count", 32'(q.size()), 32'd24);
    check_word(0,  8'h07, 2'd1, "w07");
    check_word(8,  8'h80, 2'd2, "w80");
    check_word(16, 8'hFF, 2'd0, "wFF");

    // Producer stall between words
    q.delete();
    send(8'h96);
    in_valid = 1'b0;
    step(14);
    check("stall_idle", {30'd0, ser_valid, busy}, 32'd0);
    send(8'h5B);
    in_valid = 1'b0;
    step(12);
    check("stall_count", 32'(q.size()), 32'd16);
    check_word(0, 8'h96, 2'd0, "w96");
    check_word(8, 8'h5B, 2'd1, "w5B");
    if (q.size() >= 9) check("stall_gap", 32'(q[8].cyc > q[7].cyc + 1), 32'd1);

    // Reset mid-word with a pending word
    send(8'hC3);
    send(8'h3C);
    in_valid = 1'b0;
    step(4);
    check("pre_rst_mid", {29'd0, ser_valid, busy, ser_first}, 32'h6);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_outs", {27'd0, ser_bit, ser_valid, ser_first, ser_last, busy}, 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    step(2);
    reset = 1'b0;
    step(1);
    check("rel_in_ready", 32'(in_ready), 32'd1);
    send(8'h82);
    in_valid = 1'b0;
    step(12);
    check("rst_recover_count", 32'(q.size()), 32'd8);
    check_word(0, 8'h82, 2'd1, "w82");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
